core_mc: RTL and testbench



---
 rtl/core_pkg.sv | 157 +++++++++++++++
 rtl/core_mc_fsm.sv | 94 +++++++++
 rtl/core_mc.sv | 166 ++++++++++++++++
 tb/tb_core_mc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode types and helpers for the multicycle RV32 core.
// Opcodes, FSM states, control bundle and the one-hot ALU op map.
package core_pkg;

  localparam int ALUOP_W = 14;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int A_ADD   = 0;
  localparam int A_SUB   = 1;
  localparam int A_SLL   = 2;
  localparam int A_SLT   = 3;
  localparam int A_SLTU  = 4;
  localparam int A_XOR   = 5;
  localparam int A_SRL   = 6;
  localparam int A_SRA   = 7;
  localparam int A_OR    = 8;
  localparam int A_AND   = 9;
  localparam int A_PASSB = 10;
  localparam int A_EQ    = 11;
  localparam int A_GE    = 12;
  localparam int A_GEU   = 13;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U
  } immsel_t;

  typedef enum logic [1:0] {
    ALUC_ADD,
    ALUC_OP,
    ALUC_BR,
    ALUC_LUI
  } aluclass_t;

  typedef struct packed {
    logic      regwrite;
    logic      alusrc;
    logic      memread;
    logic      memwrite;
    logic      branch;
    logic      system;
    logic      illegal;
    immsel_t   immsel;
    aluclass_t aluclass;
  } ctrl_t;

  function automatic ctrl_t control(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    c.immsel = IMM_I;
    c.aluclass = ALUC_ADD;
    unique case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.aluclass = ALUC_OP;
      end
      OP_ITYPE: begin
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.aluclass = ALUC_OP;
      end
      OP_LOAD: begin
        c.memread = 1'b1;
        c.alusrc = 1'b1;
      end
      OP_STORE: begin
        c.memwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immsel = IMM_S;
      end
      OP_BRANCH: begin
        c.branch = 1'b1;
        c.immsel = IMM_B;
        c.aluclass = ALUC_BR;
      end
      OP_LUI: begin
        c.regwrite = 1'b1;
        c.alusrc = 1'b1;
        c.immsel = IMM_U;
        c.aluclass = ALUC_LUI;
      end
      OP_SYSTEM: c.system = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Branch ops yield zero exactly when the branch is taken.
  function automatic logic [ALUOP_W-1:0] alucontrol(
    input aluclass_t  cls,
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       rtype
  );
    int idx;
    idx = A_ADD;
    unique case (cls)
      ALUC_ADD: idx = A_ADD;
      ALUC_LUI: idx = A_PASSB;
      ALUC_BR: begin
        case (f3)
          3'b001:  idx = A_EQ;
          3'b100:  idx = A_GE;
          3'b101:  idx = A_SLT;
          3'b110:  idx = A_GEU;
          3'b111:  idx = A_SLTU;
          default: idx = A_SUB;
        endcase
      end
      ALUC_OP: begin
        case (f3)
          3'b000:  idx = (f7b5 && rtype) ? A_SUB : A_ADD;
          3'b001:  idx = A_SLL;
          3'b010:  idx = A_SLT;
          3'b011:  idx = A_SLTU;
          3'b100:  idx = A_XOR;
          3'b101:  idx = f7b5 ? A_SRA : A_SRL;
          3'b110:  idx = A_OR;
          default: idx = A_AND;
        endcase
      end
    endcase
    return ALUOP_W'(1) << idx;
  endfunction

  function automatic logic [31:0] immextend(
    input logic [31:0] ir,
    input immsel_t     sel
  );
    logic [31:0] r;
    unique case (sel)
      IMM_I: r = {{20{ir[31]}}, ir[31:20]};
      IMM_S: r = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B: r = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
      IMM_U: r = {ir[31:12], 12'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_mc_fsm.sv
// Sequencer for core_mc: FETCH/EXEC/MEM/HALT state and handshakes.
// Request outputs are registered so they fall cleanly on async reset.
module core_mc_fsm
  import core_pkg::*;
(
  input  logic   clock,
  input  logic   nreset,
  input  logic   programvalid,
  input  logic   ramready,
  input  logic   illegal,
  input  logic   system,
  input  logic   memop,
  input  logic   store,
  input  logic   misaligned,
  output state_t state,
  output logic   fetchack,
  output logic   execdone,
  output logic   memstart,
  output logic   memdone,
  output logic   programreq,
  output logic   ramreq,
  output logic   writeram,
  output logic   halted,
  output logic   fault
);

  state_t nstate;
  logic   setfault;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= FETCH;
      programreq <= 1'b0;
      ramreq     <= 1'b0;
      writeram   <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= nstate;
      programreq <= (nstate == FETCH);
      ramreq     <= (nstate == MEM);
      writeram   <= (nstate == MEM) &
                    (memstart ? store : writeram);
      halted     <= (nstate == HALT);
      fault      <= fault | setfault;
    end
  end

  always_comb begin
    nstate   = state;
    fetchack = 1'b0;
    execdone = 1'b0;
    memstart = 1'b0;
    memdone  = 1'b0;
    setfault = 1'b0;
    unique case (state)
      FETCH: begin
        if (programreq && programvalid) begin
          fetchack = 1'b1;
          nstate = EXEC;
        end
      end
      EXEC: begin
        unique case (1'b1)
          illegal: begin
            setfault = 1'b1;
            nstate = HALT;
          end
          system: nstate = HALT;
          memop && misaligned: begin
            setfault = 1'b1;
            nstate = HALT;
          end
          memop && !misaligned: begin
            memstart = 1'b1;
            nstate = MEM;
          end
          default: begin
            execdone = 1'b1;
            nstate = FETCH;
          end
        endcase
      end
      MEM: begin
        if (ramready) begin
          memdone = 1'b1;
          nstate = FETCH;
        end
      end
      HALT: nstate = HALT;
    endcase
  end

endmodule

// File: rtl/core_mc.sv
// Multicycle RV32 subset core with valid/ready program and data ports.
// Define CORE_MC_PERF_EN to add instret/stallcycles counters.
module core_mc
  import core_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clock,
  input  logic             nreset,
  output logic             programreq,
  output logic [WIDTH-1:0] programaddress,
  input  logic             programvalid,
  input  logic [31:0]      programdata,
  output logic             ramreq,
  output logic             writeram,
  output logic [WIDTH-1:0] ramaddress,
  output logic [WIDTH-1:0] writeramdata,
  input  logic             ramready,
  input  logic [WIDTH-1:0] readramdata,
  output logic             halted,
  output logic             fault
`ifdef CORE_MC_PERF_EN
  ,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] stallcycles
`endif
);

  state_t             state;
  logic               fetchack;
  logic               execdone;
  logic               memstart;
  logic               memdone;
  logic [31:0]        ir;
  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   rf [32];
  logic [WIDTH-1:0]   rs1v;
  logic [WIDTH-1:0]   rs2v;
  logic [WIDTH-1:0]   imm;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   alures;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH-1:0]   maddr;
  logic [WIDTH-1:0]   sdata;
  logic [ALUOP_W-1:0] aluop;
  logic [4:0]         sh;
  logic [4:0]         rd;
  logic               zero;
  logic               rfwe;
  ctrl_t              ctl;

  assign ctl   = control(ir[6:0]);
  assign aluop = alucontrol(ctl.aluclass, ir[14:12],
                            ir[30], ir[5]);
  assign imm   = WIDTH'($signed(immextend(ir, ctl.immsel)));
  assign rd    = ir[11:7];
  assign rs1v  = rf[ir[19:15]];
  assign rs2v  = rf[ir[24:20]];
  assign opb   = ctl.alusrc ? imm : rs2v;
  assign sh    = opb[4:0];

  always_comb begin
    alures = '0;
    unique case (1'b1)
      aluop[A_ADD]:   alures = rs1v + opb;
      aluop[A_SUB]:   alures = rs1v - opb;
      aluop[A_SLL]:   alures = rs1v << sh;
      aluop[A_SLT]:   alures = WIDTH'($signed(rs1v) < $signed(opb));
      aluop[A_SLTU]:  alures = WIDTH'(rs1v < opb);
      aluop[A_XOR]:   alures = rs1v ^ opb;
      aluop[A_SRL]:   alures = rs1v >> sh;
      aluop[A_SRA]:   alures = WIDTH'($signed(rs1v) >>> sh);
      aluop[A_OR]:    alures = rs1v | opb;
      aluop[A_AND]:   alures = rs1v & opb;
      aluop[A_PASSB]: alures = opb;
      aluop[A_EQ]:    alures = WIDTH'(rs1v == opb);
      aluop[A_GE]:    alures = WIDTH'($signed(rs1v) >= $signed(opb));
      aluop[A_GEU]:   alures = WIDTH'(rs1v >= opb);
      default:        alures = '0;
    endcase
  end

  assign zero = (alures == '0);

  core_mc_fsm u_fsm (
    .clock        (clock),
    .nreset       (nreset),
    .programvalid (programvalid),
    .ramready     (ramready),
    .illegal      (ctl.illegal),
    .system       (ctl.system),
    .memop        (ctl.memread | ctl.memwrite),
    .store        (ctl.memwrite),
    .misaligned   (alures[1:0] != 2'b00),
    .state        (state),
    .fetchack     (fetchack),
    .execdone     (execdone),
    .memstart     (memstart),
    .memdone      (memdone),
    .programreq   (programreq),
    .ramreq       (ramreq),
    .writeram     (writeram),
    .halted       (halted),
    .fault        (fault)
  );

  assign programaddress = pc;
  assign ramaddress     = maddr;
  assign writeramdata   = sdata;

  assign rfwe  = (execdone & ctl.regwrite) |
                 (memdone & ctl.memread);
  assign wdata = memdone ? readramdata : alures;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      maddr <= '0;
      sdata <= '0;
    end else begin
      if (fetchack)
        ir <= programdata;
      if (memstart) begin
        maddr <= alures;
        sdata <= rs2v;
      end
      if (execdone)
        pc <= (ctl.branch && zero) ? pc + imm
                                   : pc + WIDTH'(4);
      else if (memdone)
        pc <= pc + WIDTH'(4);
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (rfwe && rd != 5'd0) begin
      rf[rd] <= wdata;
    end
  end

`ifdef CORE_MC_PERF_EN
  logic stall;

  assign stall = (state == FETCH && !programvalid) ||
                 (state == MEM && !ramready);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      instret     <= '0;
      stallcycles <= '0;
    end else begin
      if ((execdone || memdone) && !(&instret))
        instret <= instret + CNT_W'(1);
      if (stall && !(&stallcycles))
        stallcycles <= stallcycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_core_mc.sv
// Directed self-checking bench for core_mc.
// Acts as program ROM and data RAM, driving each step by hand.
module tb_core_mc;

  logic        clock = 1'b0;
  logic        nreset;
  logic        programreq;
  logic [31:0] programaddress;
  logic        programvalid;
  logic [31:0] programdata;
  logic        ramreq;
  logic        writeram;
  logic [31:0] ramaddress;
  logic [31:0] writeramdata;
  logic        ramready;
  logic [31:0] readramdata;
  logic        halted;
  logic        fault;

  logic        pr1;
  logic [31:0] pa1;
  logic        pv1 = 1'b0;
  logic [31:0] pd1 = '0;
  logic        rq1;
  logic        wr1;
  logic [31:0] ra1;
  logic [31:0] wd1;
  logic        rr1 = 1'b0;
  logic [31:0] rd1 = '0;
  logic        h1;
  logic        f1;

  int total = 0;
  int passed = 0;
  int fails = 0;

  always #5 clock = ~clock;

  core_mc #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .nreset         (nreset),
    .programreq     (programreq),
    .programaddress (programaddress),
    .programvalid   (programvalid),
    .programdata    (programdata),
    .ramreq         (ramreq),
    .writeram       (writeram),
    .ramaddress     (ramaddress),
    .writeramdata   (writeramdata),
    .ramready       (ramready),
    .readramdata    (readramdata),
    .halted         (halted),
    .fault          (fault)
  );

  core_mc #(.WIDTH(32), .RESET_PC(32'h100)) dut1 (
    .clock          (clock),
    .nreset         (nreset),
    .programreq     (pr1),
    .programaddress (pa1),
    .programvalid   (pv1),
    .programdata    (pd1),
    .ramreq         (rq1),
    .writeram       (wr1),
    .ramaddress     (ra1),
    .writeramdata   (wd1),
    .ramready       (rr1),
    .readramdata    (rd1),
    .halted         (h1),
    .fault          (f1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] ins,
                       input logic [31:0] addr,
                       input string tag);
    int n;
    n = 0;
    while (programreq !== 1'b1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_req"}, 32'(programreq), 32'd1);
    chk({tag, "_pc"}, programaddress, addr);
    programdata = ins;
    programvalid = 1'b1;
    @(negedge clock);
    programvalid = 1'b0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    programvalid = 1'b0;
    ramready = 1'b0;
    readramdata = '0;
    repeat (2) @(negedge clock);
    nreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0;
    programvalid = 1'b0;
    programdata = '0;
    ramready = 1'b0;
    readramdata = '0;

    // reset state and first request
    repeat (2) @(negedge clock);
    chk("rst_req", 32'(programreq), 32'd0);
    chk("rst_ramreq", 32'(ramreq), 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_pc100", pa1, 32'h100);
    nreset = 1'b1;
    chk("rel_req1", 32'(pr1), 32'd0);
    @(negedge clock);
    chk("first_req1", 32'(pr1), 32'd1);
    chk("first_pc1", pa1, 32'h100);
    chk("first_halt1", 32'(h1), 32'd0);
    chk("first_fault1", 32'(f1), 32'd0);

    // ALU chain
    fetch(32'h00500093, 32'h00, "addi1");
    fetch(32'h00700113, 32'h04, "addi2");
    fetch(32'h002081B3, 32'h08, "add");

    // store x3 (=12) to 4
    fetch(32'h00302223, 32'h0C, "sw3");
    ramready = 1'b1;
    @(negedge clock);
    chk("sw3_ramreq", 32'(ramreq), 32'd1);
    chk("sw3_wr", 32'(writeram), 32'd1);
    chk("sw3_addr", ramaddress, 32'd4);
    chk("sw3_data", writeramdata, 32'd12);
    @(negedge clock);
    chk("sw3_done", 32'(ramreq), 32'd0);
    ramready = 1'b0;

    // branches
    fetch(32'hFE000CE3, 32'h10, "beq");
    fetch(32'h00001863, 32'h08, "bne");

    // load with three wait cycles
    fetch(32'h00802203, 32'h0C, "lw4");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      chk("lw4_ramreq", 32'(ramreq), 32'd1);
      chk("lw4_addr", ramaddress, 32'd8);
      chk("lw4_wr", 32'(writeram), 32'd0);
      if (i == 4) begin
        ramready = 1'b1;
        readramdata = 32'hDEADBEEF;
      end
    end
    @(negedge clock);
    chk("lw4_done", 32'(ramreq), 32'd0);
    ramready = 1'b0;
    readramdata = '0;

    fetch(32'h00402823, 32'h10, "sw4");
    chk("sw4_exec", 32'(ramreq), 32'd0);
    @(negedge clock);
    chk("sw4_addr", ramaddress, 32'd16);
    chk("sw4_data", writeramdata, 32'hDEADBEEF);
    ramready = 1'b1;
    @(negedge clock);
    ramready = 1'b0;

    // negative result
    fetch(32'h402083B3, 32'h14, "sub");
    fetch(32'h00702A23, 32'h18, "sw7");
    @(negedge clock);
    chk("sw7_addr", ramaddress, 32'd20);
    chk("sw7_data", writeramdata, 32'hFFFFFFFE);
    ramready = 1'b1;
    @(negedge clock);
    ramready = 1'b0;

    // ecall halts cleanly
    fetch(32'h00000073, 32'h1C, "ecall");
    @(negedge clock);
    chk("ecall_halt", 32'(halted), 32'd1);
    chk("ecall_fault", 32'(fault), 32'd0);
    programvalid = 1'b1;
    ramready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("halt_reqs", {30'd0, programreq, ramreq}, 32'd0);
    end
    chk("halt_pc", programaddress, 32'h1C);
    chk("halt_hold", 32'(halted), 32'd1);

    // reset during MEM
    do_reset();
    fetch(32'h00802203, 32'h00, "lw_r");
    @(negedge clock);
    chk("lwr_ramreq", 32'(ramreq), 32'd1);
    #2 nreset = 1'b0;
    #1;
    chk("lwr_async", 32'(ramreq), 32'd0);
    chk("lwr_pc", programaddress, 32'h0);

    // misaligned load
    do_reset();
    chk("mis_clr", 32'(halted), 32'd0);
    fetch(32'h00202283, 32'h00, "lw_mis");
    chk("mis_exec", 32'(ramreq), 32'd0);
    @(negedge clock);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_halt", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("mis_noreq", {30'd0, programreq, ramreq}, 32'd0);
    end

    // illegal opcode
    do_reset();
    chk("ill_clr", 32'(fault), 32'd0);
    fetch(32'h0000006F, 32'h00, "jal");
    @(negedge clock);
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_halt", 32'(halted), 32'd1);
    chk("ill_req", 32'(programreq), 32'd0);

    // second core never saw programvalid
    chk("hold_req1", 32'(pr1), 32'd1);
    chk("hold_pc1", pa1, 32'h100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
